// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, ALU ops,
// immediate formats and the ID/EX bundle. Macro: ID_ILLEGAL_TRAP_EN.
package rv32_pkg;

    localparam int unsigned XLEN_W = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN_W-1:0]   pc;
        logic [31:0]         inst;
        logic [XLEN_W-1:0]   rs1_data;
        logic [XLEN_W-1:0]   rs2_data;
        logic [XLEN_W-1:0]   imm;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        alu_op_e             alu_op;
        logic [2:0]          funct3;
        logic                alu_src_imm;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                branch;
        logic                jal;
        logic                jalr;
        logic                lui;
        logic                auipc;
        logic                illegal;
    } id_ex_t;

    function automatic imm_type_e imm_type(input logic [6:0] opc);
        imm_type_e t;
        t = IMM_I;
        unique case (1'b1)
            (opc == OPC_STORE):  t = IMM_S;
            (opc == OPC_BRANCH): t = IMM_B;
            (opc == OPC_LUI),
            (opc == OPC_AUIPC):  t = IMM_U;
            (opc == OPC_JAL):    t = IMM_J;
            default:             t = IMM_I;
        endcase
        return t;
    endfunction

    // alt = inst[30]; SUB only exists for register-register ops.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_op);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (alt && is_op) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects I/S/B/U/J format from the opcode and
// sign-extends from inst[31]. Ports: inst in, imm out (XLEN).
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (imm_type(inst[6:0]))
            IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                            inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm32 = {inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                            inst[20], inst[30:21], 1'b0};
            default: imm32 = {{20{inst[31]}}, inst[31:20]};
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediate, load-use hazard, ID/EX register.
// Ports: IF handshake, regfile read, EX bundle. Macro: ID_ILLEGAL_TRAP_EN.
module id_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_NOP = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] rddata1,
    input  logic [XLEN-1:0] rddata2,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_inst,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_funct3,
    output logic            ex_alu_src_imm,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_lui,
    output logic            ex_auipc
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic            ex_illegal
`endif
);

    id_ex_t          ex_q, ex_d;
    id_ex_t          dec;
    id_ex_t          bubble;
    logic [XLEN-1:0] imm;
    logic [6:0]      opc;
    logic [4:0]      rd;
    logic            uses_rs1, uses_rs2, wr;
    logic            hazard, advance;

    assign opc = if_inst[6:0];
    assign rd  = if_inst[11:7];
    assign rs1 = if_inst[19:15];
    assign rs2 = if_inst[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (if_inst),
        .imm  (imm)
    );

    always_comb begin
        bubble      = '0;
        bubble.inst = RESET_PC_NOP;
    end

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = if_pc;
        dec.inst     = if_inst;
        dec.rs1_data = rddata1;
        dec.rs2_data = rddata2;
        dec.imm      = imm;
        dec.rd       = rd;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.funct3   = if_inst[14:12];
        dec.alu_op   = ALU_ADD;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b0;
        wr           = 1'b0;
        unique case (1'b1)
            (opc == OPC_LUI): begin
                dec.lui         = 1'b1;
                dec.alu_op      = ALU_PASS_B;
                dec.alu_src_imm = 1'b1;
                uses_rs1        = 1'b0;
                wr              = 1'b1;
            end
            (opc == OPC_AUIPC): begin
                dec.auipc       = 1'b1;
                dec.alu_src_imm = 1'b1;
                uses_rs1        = 1'b0;
                wr              = 1'b1;
            end
            (opc == OPC_JAL): begin
                dec.jal  = 1'b1;
                uses_rs1 = 1'b0;
                wr       = 1'b1;
            end
            (opc == OPC_JALR): begin
                dec.jalr        = 1'b1;
                dec.alu_src_imm = 1'b1;
                wr              = 1'b1;
            end
            (opc == OPC_BRANCH): begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                uses_rs2   = 1'b1;
            end
            (opc == OPC_LOAD): begin
                dec.mem_read    = 1'b1;
                dec.alu_src_imm = 1'b1;
                wr              = 1'b1;
            end
            (opc == OPC_STORE): begin
                dec.mem_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                uses_rs2        = 1'b1;
            end
            (opc == OPC_OP_IMM): begin
                dec.alu_op      = alu_from_f3(if_inst[14:12],
                                              if_inst[30], 1'b0);
                dec.alu_src_imm = 1'b1;
                wr              = 1'b1;
            end
            (opc == OPC_OP): begin
                dec.alu_op = alu_from_f3(if_inst[14:12],
                                         if_inst[30], 1'b1);
                uses_rs2   = 1'b1;
                wr         = 1'b1;
            end
            default: begin
`ifdef ID_ILLEGAL_TRAP_EN
                dec.illegal = 1'b1;
`else
                dec.illegal = 1'b0;
`endif
            end
        endcase
        // x0 is never a real destination.
        dec.reg_write = wr & (rd != 5'd0);
    end

    assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((uses_rs1 & (ex_q.rd == rs1)) |
                     (uses_rs2 & (ex_q.rd == rs2)));

    assign advance  = ~ex_q.valid | ex_ready;
    assign id_ready = advance & ~hazard & ~flush;

    always_comb begin
        ex_d = ex_q;
        if (flush)
            ex_d = bubble;
        else if (!advance)
            ex_d = ex_q;
        else if (hazard || !if_valid)
            ex_d = bubble;
        else
            ex_d = dec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_q <= bubble;
        else
            ex_q <= ex_d;
    end

    assign ex_valid       = ex_q.valid;
    assign ex_pc          = ex_q.pc;
    assign ex_inst        = ex_q.inst;
    assign ex_rs1_data    = ex_q.rs1_data;
    assign ex_rs2_data    = ex_q.rs2_data;
    assign ex_imm         = ex_q.imm;
    assign ex_rd          = ex_q.rd;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_funct3      = ex_q.funct3;
    assign ex_alu_src_imm = ex_q.alu_src_imm;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_branch      = ex_q.branch;
    assign ex_jal         = ex_q.jal;
    assign ex_jalr        = ex_q.jalr;
    assign ex_lui         = ex_q.lui;
    assign ex_auipc       = ex_q.auipc;
`ifdef ID_ILLEGAL_TRAP_EN
    assign ex_illegal     = ex_q.illegal;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, load-use hazard,
// downstream stall, flush and x0 handling.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  rs1, rs2;
    logic [31:0] rddata1, rddata2;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_alu_src_imm, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, ex_branch, ex_jal, ex_jalr;
    logic        ex_lui, ex_auipc;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        ex_illegal;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI  = 32'hFFC08293;
    localparam logic [31:0] I_LW6   = 32'h00012303;
    localparam logic [31:0] I_ADD7  = 32'h003303B3;
    localparam logic [31:0] I_SUB8  = 32'h40208433;
    localparam logic [31:0] I_SW    = 32'h0050A423;
    localparam logic [31:0] I_BEQ   = 32'hFE208CE3;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_LUI   = 32'h123451B7;
    localparam logic [31:0] I_ADDI0 = 32'h00500013;
    localparam logic [31:0] I_LW0   = 32'h00012003;
    localparam logic [31:0] I_ADDX0 = 32'h003003B3;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .rs1            (rs1),
        .rs2            (rs2),
        .rddata1        (rddata1),
        .rddata2        (rddata2),
        .ex_ready       (ex_ready),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_inst        (ex_inst),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_alu_op      (ex_alu_op),
        .ex_funct3      (ex_funct3),
        .ex_alu_src_imm (ex_alu_src_imm),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_lui         (ex_lui),
        .ex_auipc       (ex_auipc)
`ifdef ID_ILLEGAL_TRAP_EN
        ,
        .ex_illegal     (ex_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b1;
        if_inst  = I_ADDI;
        if_pc    = 32'h0;
        rddata1  = 32'd0;
        rddata2  = 32'd0;
        ex_ready = 1'b1;
        flush    = 1'b0;
        step();
        step();
        check("rst_valid", ex_valid, 0);
        check("rst_regwr", ex_reg_write, 0);
        check("rst_inst", ex_inst, 32'h00000013);
        check("rst_pc", ex_pc, 0);
        check("rst_imm", ex_imm, 0);

        // ADDI x5,x1,-4
        rst_n   = 1'b1;
        if_pc   = 32'h100;
        rddata1 = 32'd10;
        #1;
        check("addi_rs1", rs1, 1);
        check("addi_ready", id_ready, 1);
        step();
        check("addi_valid", ex_valid, 1);
        check("addi_rd", ex_rd, 5);
        check("addi_imm", ex_imm, 32'hFFFFFFFC);
        check("addi_src", ex_alu_src_imm, 1);
        check("addi_wr", ex_reg_write, 1);
        check("addi_d1", ex_rs1_data, 10);
        check("addi_pc", ex_pc, 32'h100);
        check("addi_alu", ex_alu_op, 0);

        // LW x6,0(x2) then dependent ADD x7,x6,x3
        if_inst = I_LW6;
        if_pc   = 32'h104;
        #1;
        check("lw_ready", id_ready, 1);
        step();
        check("lw_rd", ex_rd, 6);
        check("lw_mrd", ex_mem_read, 1);
        check("lw_wr", ex_reg_write, 1);
        if_inst = I_ADD7;
        if_pc   = 32'h108;
        #1;
        check("hz_ready", id_ready, 0);
        step();
        check("hz_bub_v", ex_valid, 0);
        check("hz_bub_mr", ex_mem_read, 0);
        check("hz_bub_in", ex_inst, 32'h00000013);
        check("hz_ready2", id_ready, 1);
        step();
        check("add_valid", ex_valid, 1);
        check("add_rs1", ex_rs1, 6);
        check("add_rs2", ex_rs2, 3);
        check("add_rd", ex_rd, 7);
        check("add_src", ex_alu_src_imm, 0);
        check("add_alu", ex_alu_op, 0);

        // SUB x8,x1,x2
        if_inst = I_SUB8;
        rddata2 = 32'd3;
        step();
        check("sub_alu", ex_alu_op, 1);
        check("sub_d2", ex_rs2_data, 3);

        // SW x5,8(x1), then EX stalls for 3 cycles
        if_inst = I_SW;
        if_pc   = 32'h110;
        rddata2 = 32'h55;
        step();
        check("sw_mw", ex_mem_write, 1);
        check("sw_imm", ex_imm, 8);
        check("sw_wr", ex_reg_write, 0);
        check("sw_d2", ex_rs2_data, 32'h55);
        ex_ready = 1'b0;
        if_inst  = I_BEQ;
        if_pc    = 32'h114;
        #1;
        check("stall_rdy0", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_inst", ex_inst, I_SW);
            check("stall_pc", ex_pc, 32'h110);
            check("stall_v", ex_valid, 1);
            check("stall_rdy", id_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        check("resume_rdy", id_ready, 1);
        step();
        check("beq_inst", ex_inst, I_BEQ);
        check("beq_br", ex_branch, 1);
        check("beq_imm", ex_imm, 32'hFFFFFFF8);
        check("beq_alu", ex_alu_op, 1);
        check("beq_wr", ex_reg_write, 0);

        // JAL x1,+16 and LUI x3,0x12345
        if_inst = I_JAL;
        step();
        check("jal_j", ex_jal, 1);
        check("jal_imm", ex_imm, 32'h10);
        check("jal_wr", ex_reg_write, 1);
        if_inst = I_LUI;
        step();
        check("lui_l", ex_lui, 1);
        check("lui_imm", ex_imm, 32'h12345000);
        check("lui_alu", ex_alu_op, 10);
        check("lui_rd", ex_rd, 3);

        // Flush alone kills the instruction in ID
        if_inst = I_ADDI;
        flush   = 1'b1;
        #1;
        check("fl_ready", id_ready, 0);
        step();
        check("fl_valid", ex_valid, 0);
        check("fl_wr", ex_reg_write, 0);
        flush = 1'b0;

        // Flush while a load-use hazard is pending
        if_inst = I_LW6;
        step();
        check("fh_lw_mr", ex_mem_read, 1);
        if_inst = I_ADD7;
        flush   = 1'b1;
        #1;
        check("fh_ready", id_ready, 0);
        step();
        check("fh_valid", ex_valid, 0);
        check("fh_mr", ex_mem_read, 0);
        flush = 1'b0;
        #1;
        check("fh_ready2", id_ready, 1);

        // x0 destination
        if_inst = I_ADDI0;
        step();
        check("x0_valid", ex_valid, 1);
        check("x0_wr", ex_reg_write, 0);
        check("x0_imm", ex_imm, 5);
        if_inst = I_LW0;
        step();
        check("lw0_mr", ex_mem_read, 1);
        check("lw0_wr", ex_reg_write, 0);
        if_inst = I_ADDX0;
        #1;
        check("x0_nohz", id_ready, 1);
        step();
        check("x0_add_v", ex_valid, 1);
        check("x0_add_rd", ex_rd, 7);

        // Unknown opcode
        if_inst = I_BAD;
        step();
        check("bad_valid", ex_valid, 1);
        check("bad_wr", ex_reg_write, 0);
        check("bad_mr", ex_mem_read, 0);
        check("bad_mw", ex_mem_write, 0);
`ifdef ID_ILLEGAL_TRAP_EN
        check("bad_ill", ex_illegal, 1);
`endif

        // No valid instruction from IF
        if_valid = 1'b0;
        if_inst  = I_ADDI;
        step();
        check("idle_valid", ex_valid, 0);
        check("idle_wr", ex_reg_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
